tiny16_control: RTL and testbench
=================================

# tiny16_control

Instruction sequencer for the tiny16 CPU. Fetches 16-bit instructions from `memory`, decodes them, drives the `registers` select/enable lines and the `alu` opcode/operands, and writes results back to the register file or memory. Sits between the top level and the three datapath blocks; it is the only driver of their control inputs.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 16, data/instruction width
- `RESET_PC`, 16'h0000, first fetch address after reset

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_out_en`  out  1  memory read strobe
- `mem_out_addr`  out  ADDR_W  memory read address
- `mem_out_data`  in  DATA_W  memory read data, valid the cycle after `mem_out_en`
- `mem_in_en`  out  1  memory write strobe
- `mem_in_addr`  out  ADDR_W  memory write address
- `mem_in_data`  out  DATA_W  memory write data
- `reg_src_sel`, `reg_dst_sel`  out  4 each  register read selects
- `reg_out_en`  out  1  register read strobe; `reg_src`/`reg_dst` valid next cycle
- `reg_src`, `reg_dst`  in  DATA_W each  register read data
- `reg_in_en`  out  1  register write strobe, writes `reg_in` to `reg_dst_sel`
- `reg_in`  out  DATA_W  register write data
- `alu_opcode`  out  4  ALU operation; `alu_ar_flag`  out  1  arithmetic flag (= IR[3])
- `alu_src1`, `alu_src2`  out  DATA_W each  ALU operands; `alu_dst`  in  DATA_W  ALU result (combinational)
- `pc`  out  ADDR_W  current program counter; `halted`  out  1  HLT executed

## Operation
- Format: IR[15:12] opcode, IR[11:8] rd, IR[7:4] rs, IR[3:0] func; LDI uses IR[7:0] as imm8.
- Opcodes: 0x0 NOP; 0x1–0x7 ALU (`alu_opcode`=opcode, src1=R[rd], src2=R[rs], R[rd]←`alu_dst`); 0x8 LDI R[rd]←{8'h00,imm8}; 0x9 LD R[rd]←M[R[rs]]; 0xA ST M[R[rd]]←R[rs]; 0xB JMP pc←R[rs]; 0xC JZ (see Configuration); 0xF HLT; others NOP.
- States: FETCH → DECODE → READ → EXEC → FETCH; LD: EXEC → MEM → WB → FETCH; HLT: EXEC → HALT (terminal until reset).
- FETCH: `mem_out_en`=1, `mem_out_addr`=pc. DECODE: IR←`mem_out_data`. READ: selects from IR, `reg_out_en`=1. EXEC: operands valid, one write strobe or pc update. pc←pc+1 in EXEC unless JMP/taken JZ; 16-bit wrap 16'hFFFF→16'h0000.
- `mem_in_en` and `reg_in_en` never both high; every strobe is exactly one cycle.

## Timing
- Reset (async assert, sync release): state=FETCH, pc=`RESET_PC`, IR=0, `halted`=0, zero flag=0, all strobes/selects/data outputs 0. First `mem_out_en` in the first cycle after release.
- Latency: 4 cycles per instruction; LD 6 cycles (MEM issues `mem_out_en` with addr=R[rs], WB asserts `reg_in_en`).
- Reset mid-instruction aborts immediately; no partial write strobe is issued.
- HALT: all strobes 0, pc frozen, `halted`=1.

## Configuration
- `TINY16_JZ_EN` defined: 1-bit zero flag updated on every ALU write (`alu_dst`==0); JZ sets pc←R[rs] if flag set, else pc+1. LDI/LD do not affect the flag.
- Undefined: no flag register; opcode 0xC executes as NOP (4 cycles, pc+1).

## Structure
- Package `tiny16_pkg`: opcode localparams, state enum, instruction field positions.
- Sub-module `tiny16_decode`: combinational IR → {is_alu, is_ldi, is_ld, is_st, is_jmp, is_jz, is_hlt, rd, rs, imm8}.

## Test plan
- Reset release, M[0]=16'h8105 (LDI R1,5) → cycle 4 `reg_in_en`=1, `reg_dst_sel`=1, `reg_in`=16'h0005; pc=1.
- R1=5, R2=3, ADD 16'h1120 → `alu_opcode`=1, src1=5, src2=3, R1 written with `alu_dst`.
- LD 16'h9320 with R2=16'h0040, M[0x40]=16'hBEEF → R3=16'hBEEF, next fetch 6 cycles after LD fetch.
- pc=16'hFFFF with NOP → next `mem_out_addr`=16'h0000; HLT 16'hF000 → `halted`=1, no further strobes.
- `TINY16_JZ_EN`: SUB yielding 0 then JZ R4=16'h0020 → pc=16'h0020; without macro → pc+1.
- Assert `rst` during EXEC of ST → `mem_in_en` never pulses, pc=`RESET_PC` after release.

Source files
------------

// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 sequencer: opcodes, instruction field
// positions, FSM state encoding and the decoded-instruction bundle.
package tiny16_pkg;

    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_LD  = 4'h9;
    localparam logic [3:0] OP_ST  = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int AR_BIT  = 3;
    localparam int IMM_W   = 8;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic             is_alu;
        logic             is_ldi;
        logic             is_ld;
        logic             is_st;
        logic             is_jmp;
        logic             is_jz;
        logic             is_hlt;
        logic [3:0]       rd;
        logic [3:0]       rs;
        logic [IMM_W-1:0] imm8;
    } dec_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h7);
    endfunction

endpackage

// File: rtl/tiny16_if.sv
// Control bus between the tiny16 sequencer (master) and the memory,
// register-file and ALU datapath blocks (slave).
interface tiny16_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Every *_en is a single-cycle strobe qualified by nothing else: a read
    // strobe returns data on the following cycle, a write strobe commits on
    // the clock edge that ends its cycle. There is no back-pressure.
    logic              mem_out_en;
    logic [ADDR_W-1:0] mem_out_addr;
    logic [DATA_W-1:0] mem_out_data;
    logic              mem_in_en;
    logic [ADDR_W-1:0] mem_in_addr;
    logic [DATA_W-1:0] mem_in_data;
    logic [3:0]        reg_src_sel;
    logic [3:0]        reg_dst_sel;
    logic              reg_out_en;
    logic [DATA_W-1:0] reg_src;
    logic [DATA_W-1:0] reg_dst;
    logic              reg_in_en;
    logic [DATA_W-1:0] reg_in;
    logic [3:0]        alu_opcode;
    logic              alu_ar_flag;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [DATA_W-1:0] alu_dst;

    modport master (
        output mem_out_en, mem_out_addr, mem_in_en, mem_in_addr, mem_in_data,
        output reg_src_sel, reg_dst_sel, reg_out_en, reg_in_en, reg_in,
        output alu_opcode, alu_ar_flag, alu_src1, alu_src2,
        input  mem_out_data, reg_src, reg_dst, alu_dst
    );

    modport slave (
        input  mem_out_en, mem_out_addr, mem_in_en, mem_in_addr, mem_in_data,
        input  reg_src_sel, reg_dst_sel, reg_out_en, reg_in_en, reg_in,
        input  alu_opcode, alu_ar_flag, alu_src1, alu_src2,
        output mem_out_data, reg_src, reg_dst, alu_dst
    );

endinterface

// File: rtl/tiny16_decode.sv
// Combinational instruction decoder for tiny16. JZ is recognised only when
// TINY16_JZ_EN is defined; otherwise opcode 0xC decodes as a NOP.
module tiny16_decode
    import tiny16_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);

    logic [3:0] op;
    assign op = ir[OPC_LSB +: 4];

    always_comb begin
        dec        = '0;
        dec.is_alu = is_alu_op(op);
        dec.is_ldi = (op == OP_LDI);
        dec.is_ld  = (op == OP_LD);
        dec.is_st  = (op == OP_ST);
        dec.is_jmp = (op == OP_JMP);
`ifdef TINY16_JZ_EN
        dec.is_jz  = (op == OP_JZ);
`else
        dec.is_jz  = 1'b0;
`endif
        dec.is_hlt = (op == OP_HLT);
        dec.rd     = ir[RD_LSB +: 4];
        dec.rs     = ir[RS_LSB +: 4];
        dec.imm8   = ir[IMM_W-1:0];
    end

endmodule

// File: rtl/tiny16_control.sv
// tiny16 instruction sequencer: FETCH/DECODE/READ/EXEC (+MEM/WB for LD).
// Optional zero flag and JZ branch are enabled with TINY16_JZ_EN.
module tiny16_control
    import tiny16_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    tiny16_if.master          bus,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output state_t            state
);

    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ld_addr;
    logic              run;
    logic              zero_flag;
    dec_t              dec;

    tiny16_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

`ifndef TINY16_JZ_EN
    assign zero_flag = 1'b0;
`endif

    // run holds every strobe low while reset is asserted and delays the
    // first fetch to the first full cycle after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            ld_addr <= '0;
            run     <= 1'b0;
`ifdef TINY16_JZ_EN
            zero_flag <= 1'b0;
`endif
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            unique case (state)
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    ir    <= bus.mem_out_data;
                    state <= ST_READ;
                end
                ST_READ:   state <= ST_EXEC;
                ST_EXEC: begin
                    if (dec.is_jmp || (dec.is_jz && zero_flag))
                        pc <= ADDR_W'(bus.reg_src);
                    else
                        pc <= pc + ADDR_W'(1);
`ifdef TINY16_JZ_EN
                    if (dec.is_alu)
                        zero_flag <= (bus.alu_dst == '0);
`endif
                    if (dec.is_ld) begin
                        ld_addr <= ADDR_W'(bus.reg_src);
                        state   <= ST_MEM;
                    end else if (dec.is_hlt) begin
                        state <= ST_HALT;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_MEM:    state <= ST_WB;
                ST_WB:     state <= ST_FETCH;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    assign halted = (state == ST_HALT);

    // Strobes and operand routing decode from the registered state; EXEC data
    // is combinational because the ALU result only exists in that cycle.
    always_comb begin
        bus.mem_out_en   = 1'b0;
        bus.mem_out_addr = '0;
        bus.mem_in_en    = 1'b0;
        bus.mem_in_addr  = '0;
        bus.mem_in_data  = '0;
        bus.reg_src_sel  = dec.rs;
        bus.reg_dst_sel  = dec.rd;
        bus.reg_out_en   = 1'b0;
        bus.reg_in_en    = 1'b0;
        bus.reg_in       = '0;
        bus.alu_opcode   = '0;
        bus.alu_ar_flag  = 1'b0;
        bus.alu_src1     = '0;
        bus.alu_src2     = '0;
        if (run) begin
            unique case (state)
                ST_FETCH: begin
                    bus.mem_out_en   = 1'b1;
                    bus.mem_out_addr = pc;
                end
                ST_READ: bus.reg_out_en = 1'b1;
                ST_EXEC: begin
                    if (dec.is_alu) begin
                        bus.alu_opcode  = ir[OPC_LSB +: 4];
                        bus.alu_ar_flag = ir[AR_BIT];
                        bus.alu_src1    = bus.reg_dst;
                        bus.alu_src2    = bus.reg_src;
                        bus.reg_in_en   = 1'b1;
                        bus.reg_in      = bus.alu_dst;
                    end else if (dec.is_ldi) begin
                        bus.reg_in_en = 1'b1;
                        bus.reg_in    = {{(DATA_W-IMM_W){1'b0}}, dec.imm8};
                    end else if (dec.is_st) begin
                        bus.mem_in_en   = 1'b1;
                        bus.mem_in_addr = ADDR_W'(bus.reg_dst);
                        bus.mem_in_data = bus.reg_src;
                    end
                end
                ST_MEM: begin
                    bus.mem_out_en   = 1'b1;
                    bus.mem_out_addr = ld_addr;
                end
                ST_WB: begin
                    bus.reg_in_en = 1'b1;
                    bus.reg_in    = bus.mem_out_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny16_control.sv
// Directed bench for tiny16_control with behavioural memory, register file
// and ALU models around the sequencer.
module tb_tiny16_control;
    import tiny16_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic        halted;
    state_t      dut_state;

    tiny16_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    tiny16_control #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.master),
        .pc     (pc),
        .halted (halted),
        .state  (dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] regs [0:15];
    int check_cnt   = 0;
    int pass_cnt    = 0;
    int mem_in_cnt  = 0;
    int overlap_cnt = 0;
    int strobe_cnt  = 0;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    always_comb begin
        case (bus.alu_opcode)
            4'h1:    bus.alu_dst = bus.alu_src1 + bus.alu_src2;
            4'h2:    bus.alu_dst = bus.alu_src1 - bus.alu_src2;
            4'h3:    bus.alu_dst = bus.alu_src1 & bus.alu_src2;
            4'h4:    bus.alu_dst = bus.alu_src1 | bus.alu_src2;
            4'h5:    bus.alu_dst = bus.alu_src1 ^ bus.alu_src2;
            4'h6:    bus.alu_dst = bus.alu_src1 << bus.alu_src2[3:0];
            4'h7:    bus.alu_dst = bus.alu_src1 >> bus.alu_src2[3:0];
            default: bus.alu_dst = 16'h0000;
        endcase
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            bus.reg_src <= 16'h0000;
            bus.reg_dst <= 16'h0000;
        end else begin
            if (bus.reg_out_en) begin
                bus.reg_src <= regs[bus.reg_src_sel];
                bus.reg_dst <= regs[bus.reg_dst_sel];
            end
            if (bus.reg_in_en) regs[bus.reg_dst_sel] <= bus.reg_in;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_out_en) bus.mem_out_data <= mem_rd(bus.mem_out_addr);
        if (bus.mem_in_en) mem_in_cnt++;
        if (bus.mem_in_en && bus.reg_in_en) overlap_cnt++;
        if (bus.mem_out_en || bus.mem_in_en || bus.reg_out_en || bus.reg_in_en) strobe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        mem.delete();
        tick();
    endtask

    // Release reset and land in cycle 1 (the first FETCH).
    task automatic go();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        hold_reset();
        tick();
        check_cnt++; if (dut_state !== ST_FETCH) $display("FAIL rst_state: got %0d want %0d", dut_state, ST_FETCH); else pass_cnt++;
        check_cnt++; if (pc !== 16'h0000) $display("FAIL rst_pc: got %h want 0000", pc); else pass_cnt++;
        check_cnt++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else pass_cnt++;
        check_cnt++; if ({bus.mem_out_en, bus.mem_in_en, bus.reg_out_en, bus.reg_in_en} !== 4'b0000)
            $display("FAIL rst_strobes: got %b want 0000", {bus.mem_out_en, bus.mem_in_en, bus.reg_out_en, bus.reg_in_en}); else pass_cnt++;
        check_cnt++; if ({bus.reg_src_sel, bus.reg_dst_sel} !== 8'h00) $display("FAIL rst_sels: got %h want 00", {bus.reg_src_sel, bus.reg_dst_sel}); else pass_cnt++;
        go();
        check_cnt++; if (bus.mem_out_en !== 1'b1) $display("FAIL first_fetch_en: got %b want 1", bus.mem_out_en); else pass_cnt++;
        check_cnt++; if (bus.mem_out_addr !== 16'h0000) $display("FAIL first_fetch_addr: got %h want 0000", bus.mem_out_addr); else pass_cnt++;
    endtask

    task automatic test_ldi();
        hold_reset();
        mem[16'h0000] = 16'h8105;
        mem[16'h0001] = 16'hF000;
        go();
        run(2);
        check_cnt++; if (bus.reg_out_en !== 1'b1) $display("FAIL ldi_read_en: got %b want 1", bus.reg_out_en); else pass_cnt++;
        run(1);
        check_cnt++; if (bus.reg_in_en !== 1'b1) $display("FAIL ldi_wr_en: got %b want 1", bus.reg_in_en); else pass_cnt++;
        check_cnt++; if (bus.reg_dst_sel !== 4'h1) $display("FAIL ldi_dst_sel: got %h want 1", bus.reg_dst_sel); else pass_cnt++;
        check_cnt++; if (bus.reg_in !== 16'h0005) $display("FAIL ldi_data: got %h want 0005", bus.reg_in); else pass_cnt++;
        check_cnt++; if (bus.mem_in_en !== 1'b0) $display("FAIL ldi_no_mem_wr: got %b want 0", bus.mem_in_en); else pass_cnt++;
        run(1);
        check_cnt++; if (pc !== 16'h0001) $display("FAIL ldi_pc: got %h want 0001", pc); else pass_cnt++;
        check_cnt++; if (regs[1] !== 16'h0005) $display("FAIL ldi_r1: got %h want 0005", regs[1]); else pass_cnt++;
        check_cnt++; if (bus.mem_out_addr !== 16'h0001) $display("FAIL ldi_next_fetch: got %h want 0001", bus.mem_out_addr); else pass_cnt++;
    endtask

    task automatic test_alu();
        hold_reset();
        mem[16'h0000] = 16'h8105;
        mem[16'h0001] = 16'h8203;
        mem[16'h0002] = 16'h1120;
        mem[16'h0003] = 16'hF000;
        go();
        run(11);
        check_cnt++; if (bus.alu_opcode !== 4'h1) $display("FAIL alu_opcode: got %h want 1", bus.alu_opcode); else pass_cnt++;
        check_cnt++; if (bus.alu_src1 !== 16'h0005) $display("FAIL alu_src1: got %h want 0005", bus.alu_src1); else pass_cnt++;
        check_cnt++; if (bus.alu_src2 !== 16'h0003) $display("FAIL alu_src2: got %h want 0003", bus.alu_src2); else pass_cnt++;
        check_cnt++; if (bus.alu_ar_flag !== 1'b0) $display("FAIL alu_ar: got %b want 0", bus.alu_ar_flag); else pass_cnt++;
        check_cnt++; if (bus.reg_in_en !== 1'b1 || bus.reg_in !== 16'h0008)
            $display("FAIL alu_wb: got en=%b data=%h want en=1 data=0008", bus.reg_in_en, bus.reg_in); else pass_cnt++;
        run(1);
        check_cnt++; if (regs[1] !== 16'h0008) $display("FAIL alu_r1: got %h want 0008", regs[1]); else pass_cnt++;
    endtask

    task automatic test_ld();
        hold_reset();
        mem[16'h0000] = 16'h8240;
        mem[16'h0001] = 16'h9320;
        mem[16'h0002] = 16'hF000;
        mem[16'h0040] = 16'hBEEF;
        go();
        run(7);
        check_cnt++; if (bus.mem_out_en !== 1'b0 || bus.reg_in_en !== 1'b0)
            $display("FAIL ld_exec_quiet: got mo=%b ri=%b want 0 0", bus.mem_out_en, bus.reg_in_en); else pass_cnt++;
        run(1);
        check_cnt++; if (bus.mem_out_en !== 1'b1 || bus.mem_out_addr !== 16'h0040)
            $display("FAIL ld_mem_rd: got en=%b addr=%h want en=1 addr=0040", bus.mem_out_en, bus.mem_out_addr); else pass_cnt++;
        run(1);
        check_cnt++; if (bus.reg_in_en !== 1'b1 || bus.reg_dst_sel !== 4'h3 || bus.reg_in !== 16'hBEEF)
            $display("FAIL ld_wb: got en=%b sel=%h data=%h want 1 3 beef", bus.reg_in_en, bus.reg_dst_sel, bus.reg_in); else pass_cnt++;
        run(1);
        check_cnt++; if (bus.mem_out_en !== 1'b1 || bus.mem_out_addr !== 16'h0002)
            $display("FAIL ld_next_fetch: got en=%b addr=%h want en=1 addr=0002", bus.mem_out_en, bus.mem_out_addr); else pass_cnt++;
        check_cnt++; if (regs[3] !== 16'hBEEF) $display("FAIL ld_r3: got %h want beef", regs[3]); else pass_cnt++;
    endtask

    task automatic test_halt();
        int snap;
        hold_reset();
        mem[16'h0000] = 16'hF000;
        go();
        run(3);
        check_cnt++; if (halted !== 1'b0) $display("FAIL hlt_exec_halted: got %b want 0", halted); else pass_cnt++;
        run(1);
        check_cnt++; if (halted !== 1'b1) $display("FAIL hlt_halted: got %b want 1", halted); else pass_cnt++;
        check_cnt++; if (pc !== 16'h0001) $display("FAIL hlt_pc: got %h want 0001", pc); else pass_cnt++;
        snap = strobe_cnt;
        run(10);
        check_cnt++; if (strobe_cnt - snap !== 0) $display("FAIL hlt_strobes: got %0d want 0", strobe_cnt - snap); else pass_cnt++;
        check_cnt++; if (pc !== 16'h0001 || dut_state !== ST_HALT)
            $display("FAIL hlt_frozen: got pc=%h state=%0d want 0001 %0d", pc, dut_state, ST_HALT); else pass_cnt++;
    endtask

    task automatic test_pc_wrap();
        hold_reset();
        mem[16'h0000] = 16'h8101;
        mem[16'h0001] = 16'h2510;
        mem[16'h0002] = 16'hB050;
        mem[16'hFFFF] = 16'h0000;
        go();
        run(7);
        check_cnt++; if (bus.reg_in !== 16'hFFFF) $display("FAIL wrap_sub: got %h want ffff", bus.reg_in); else pass_cnt++;
        run(5);
        check_cnt++; if (bus.mem_out_addr !== 16'hFFFF || pc !== 16'hFFFF)
            $display("FAIL wrap_jmp: got addr=%h pc=%h want ffff ffff", bus.mem_out_addr, pc); else pass_cnt++;
        run(4);
        check_cnt++; if (bus.mem_out_en !== 1'b1 || bus.mem_out_addr !== 16'h0000)
            $display("FAIL wrap_fetch: got en=%b addr=%h want en=1 addr=0000", bus.mem_out_en, bus.mem_out_addr); else pass_cnt++;
        check_cnt++; if (pc !== 16'h0000) $display("FAIL wrap_pc: got %h want 0000", pc); else pass_cnt++;
    endtask

    task automatic test_st();
        int snap;
        hold_reset();
        mem[16'h0000] = 16'h8110;
        mem[16'h0001] = 16'h8277;
        mem[16'h0002] = 16'hA120;
        mem[16'h0003] = 16'hF000;
        snap = mem_in_cnt;
        go();
        run(11);
        check_cnt++; if (bus.mem_in_en !== 1'b1 || bus.mem_in_addr !== 16'h0010 || bus.mem_in_data !== 16'h0077)
            $display("FAIL st_write: got en=%b addr=%h data=%h want 1 0010 0077", bus.mem_in_en, bus.mem_in_addr, bus.mem_in_data); else pass_cnt++;
        check_cnt++; if (bus.reg_in_en !== 1'b0) $display("FAIL st_no_reg_wr: got %b want 0", bus.reg_in_en); else pass_cnt++;
        run(1);
        check_cnt++; if (mem_in_cnt - snap !== 1) $display("FAIL st_count: got %0d want 1", mem_in_cnt - snap); else pass_cnt++;
        check_cnt++; if (pc !== 16'h0003) $display("FAIL st_pc: got %h want 0003", pc); else pass_cnt++;
    endtask

    task automatic test_reset_mid_st();
        int snap;
        hold_reset();
        mem[16'h0000] = 16'h8110;
        mem[16'h0001] = 16'h8277;
        mem[16'h0002] = 16'hA120;
        mem[16'h0003] = 16'hF000;
        snap = mem_in_cnt;
        go();
        run(11);
        #2;
        rst = 1'b0;
        #1;
        check_cnt++; if (bus.mem_in_en !== 1'b0) $display("FAIL abort_strobe: got %b want 0", bus.mem_in_en); else pass_cnt++;
        check_cnt++; if (pc !== 16'h0000 || dut_state !== ST_FETCH)
            $display("FAIL abort_state: got pc=%h state=%0d want 0000 %0d", pc, dut_state, ST_FETCH); else pass_cnt++;
        run(2);
        go();
        check_cnt++; if (mem_in_cnt - snap !== 0) $display("FAIL abort_no_write: got %0d want 0", mem_in_cnt - snap); else pass_cnt++;
        check_cnt++; if (bus.mem_out_en !== 1'b1 || bus.mem_out_addr !== 16'h0000)
            $display("FAIL abort_refetch: got en=%b addr=%h want en=1 addr=0000", bus.mem_out_en, bus.mem_out_addr); else pass_cnt++;
    endtask

    task automatic test_jz();
        logic [15:0] exp_pc;
`ifdef TINY16_JZ_EN
        exp_pc = 16'h0020;
`else
        exp_pc = 16'h0005;
`endif
        hold_reset();
        mem[16'h0000] = 16'h8420;
        mem[16'h0001] = 16'h8103;
        mem[16'h0002] = 16'h8203;
        mem[16'h0003] = 16'h2120;
        mem[16'h0004] = 16'hC040;
        mem[16'h0005] = 16'hF000;
        mem[16'h0020] = 16'hF000;
        go();
        run(15);
        check_cnt++; if (bus.reg_in_en !== 1'b1 || bus.reg_in !== 16'h0000)
            $display("FAIL jz_sub_zero: got en=%b data=%h want 1 0000", bus.reg_in_en, bus.reg_in); else pass_cnt++;
        run(4);
        check_cnt++; if (bus.reg_in_en !== 1'b0 || bus.mem_in_en !== 1'b0)
            $display("FAIL jz_exec_quiet: got ri=%b mi=%b want 0 0", bus.reg_in_en, bus.mem_in_en); else pass_cnt++;
        run(1);
        check_cnt++; if (pc !== exp_pc) $display("FAIL jz_pc: got %h want %h", pc, exp_pc); else pass_cnt++;
        check_cnt++; if (bus.mem_out_addr !== exp_pc) $display("FAIL jz_fetch: got %h want %h", bus.mem_out_addr, exp_pc); else pass_cnt++;
    endtask

    task automatic test_exclusive_strobes();
        check_cnt++; if (overlap_cnt !== 0) $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_ldi();
        test_alu();
        test_ld();
        test_halt();
        test_pc_wrap();
        test_st();
        test_reset_mid_st();
        test_jz();
        test_exclusive_strobes();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
